// File: rtl/tb_cigar_encoder_if.sv
// Record stream from the CIGAR encoder FIFO head
// toward the host/DMA packer.
interface tb_cigar_encoder_if #(
  parameter int LEN_WIDTH = 12
);
  logic [1:0]           out_op;
  logic [LEN_WIDTH-1:0] out_len;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_op,
    output out_len,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_op,
    input  out_len,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/tb_cigar_encoder.sv
// Run-length encoder for the traceback direction stream,
// emitting (op, len, last) records through a FWFT FIFO.
module tb_cigar_encoder #(
  parameter int LEN_WIDTH      = 12,
  parameter int OPS_WIDTH      = 12,
  parameter int LOG_FIFO_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           dir_in,
  input  logic                 dir_valid,
  input  logic                 tb_done,
  tb_cigar_encoder_if.master   rec,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [OPS_WIDTH-1:0] num_ops
);

  localparam int DEPTH = 1 << LOG_FIFO_DEPTH;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  state_t state;

  logic                 run_valid;
  logic [1:0]           run_op;
  logic [LEN_WIDTH-1:0] run_len;

  logic [1:0]           mem_op   [DEPTH];
  logic [LEN_WIDTH-1:0] mem_len  [DEPTH];
  logic                 mem_last [DEPTH];

  logic [LOG_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG_FIFO_DEPTH:0]   count;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic dv;
  logic brk;
  logic push_req;
  logic push;

  logic [1:0]           p_op;
  logic [LEN_WIDTH-1:0] p_len;
  logic                 p_last;

  assign fifo_empty = (count == '0);
  assign fifo_full  =
    (count == (LOG_FIFO_DEPTH+1)'(DEPTH));
  assign pop        = !fifo_empty && rec.out_ready;
  assign push_ok    = !fifo_full || pop;

  assign dv  = (state == RUN) && dir_valid &&
               (dir_in != 2'd0);
  assign brk = dv && run_valid &&
               ((dir_in != run_op) ||
                (run_len == LEN_MAX));

  assign push = push_req && push_ok;

  assign rec.out_valid = !fifo_empty;
  assign rec.out_op    =
    fifo_empty ? 2'd0 : mem_op[rd_ptr];
  assign rec.out_len   =
    fifo_empty ? '0 : mem_len[rd_ptr];
  assign rec.out_last  =
    fifo_empty ? 1'b0 : mem_last[rd_ptr];

  // Select the record to push: a closed run or the final flush
  always_comb begin
    push_req = 1'b0;
    p_op     = run_op;
    p_len    = run_len;
    p_last   = 1'b0;
    unique case (1'b1)
      (state == FLUSH): begin
        push_req = 1'b1;
        p_last   = 1'b1;
        if (!run_valid) begin
          p_op  = 2'd0;
          p_len = '0;
        end
      end
      brk: push_req = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= p_op;
      mem_len[wr_ptr]  <= p_len;
      mem_last[wr_ptr] <= p_last;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Control FSM with run register and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run_valid <= 1'b0;
      run_op    <= 2'd0;
      run_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      num_ops   <= '0;
    end else begin
      done <= 1'b0;
      if (push && (num_ops != '1))
        num_ops <= num_ops + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            run_valid <= 1'b0;
            overflow  <= 1'b0;
            num_ops   <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (dv) begin
            if (!run_valid || brk) begin
              run_valid <= 1'b1;
              run_op    <= dir_in;
              run_len   <= LEN_WIDTH'(1);
            end else begin
              run_len <= run_len + 1'b1;
            end
          end
          if (push_req && !push_ok)
            overflow <= 1'b1;
          if (tb_done)
            state <= FLUSH;
        end
        FLUSH: begin
          if (push) begin
            run_valid <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_cigar_encoder.sv
// Bench for tb_cigar_encoder: directed scenarios plus
// randomized runs against a run-length reference model.
module tb_tb_cigar_encoder;

  localparam int LW   = 4;
  localparam int OW   = 12;
  localparam int LD   = 2;
  localparam int MAXL = (1 << LW) - 1;

  typedef struct packed {
    logic [1:0]    op;
    logic [LW-1:0] len;
    logic          last;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    dir_in = 2'd0;
  logic          dir_valid = 1'b0;
  logic          tb_done = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [OW-1:0] num_ops;

  tb_cigar_encoder_if #(.LEN_WIDTH(LW)) rec();

  tb_cigar_encoder #(
    .LEN_WIDTH(LW),
    .OPS_WIDTH(OW),
    .LOG_FIFO_DEPTH(LD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dir_in(dir_in),
    .dir_valid(dir_valid),
    .tb_done(tb_done),
    .rec(rec),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .num_ops(num_ops)
  );

  always #5 clk = ~clk;

  int   vec = 0;
  int   errs = 0;
  int   done_cnt = 0;
  int   got_at_done = 0;
  bit   rnd_rdy = 1'b0;
  int   dq[$];
  rec_t eq[$];
  rec_t got[$];

  // Observe pops and done pulses mid-cycle
  always @(negedge clk) begin
    if (rec.out_valid && rec.out_ready)
      got.push_back({rec.out_op, rec.out_len,
                     rec.out_last});
    if (done) begin
      done_cnt++;
      got_at_done = got.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy)
      rec.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: maximal runs, then split into saturated chunks
  task automatic build_model();
    int ops[$];
    int lens[$];
    eq.delete();
    foreach (dq[i]) begin
      if (dq[i] == 0) continue;
      if (ops.size() > 0 && ops[ops.size()-1] == dq[i])
        lens[lens.size()-1] += 1;
      else begin
        ops.push_back(dq[i]);
        lens.push_back(1);
      end
    end
    foreach (ops[i]) begin
      int l = lens[i];
      while (l > 0) begin
        int c = (l > MAXL) ? MAXL : l;
        eq.push_back({2'(ops[i]), LW'(c), 1'b0});
        l -= c;
      end
    end
    if (eq.size() == 0)
      eq.push_back({2'd0, LW'(0), 1'b1});
    else
      eq[eq.size()-1].last = 1'b1;
  endtask

  task automatic play(input int gap_max,
                      input bit with_last);
    got.delete();
    done_cnt = 0;
    got_at_done = -1;
    build_model();
    dir_valid = 1'b1;
    dir_in = 2'd3;
    tb_done = 1'b1;
    tick();
    dir_valid = 1'b0;
    tb_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (dq[i]) begin
      dir_in = 2'(dq[i]);
      dir_valid = 1'b1;
      if (with_last && i == dq.size() - 1)
        tb_done = 1'b1;
      tick();
      dir_valid = 1'b0;
      tb_done = 1'b0;
      dir_in = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, gap_max)) tick();
    end
    if (!with_last || dq.size() == 0) begin
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 500) begin
      tick();
      n++;
    end
    vec++;
    if (done_cnt == 0) begin
      errs++;
      $display("FAIL %s done timeout got 0 exp 1", nm);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rec.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    vec += 8;
    if (rec.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid got %b exp 0",
               rec.out_valid);
    end
    if (rec.out_last !== 1'b0) begin
      errs++;
      $display("FAIL rst_last got %b exp 0",
               rec.out_last);
    end
    if (rec.out_op !== 2'd0) begin
      errs++;
      $display("FAIL rst_op got %0d exp 0", rec.out_op);
    end
    if (rec.out_len !== '0) begin
      errs++;
      $display("FAIL rst_len got %0d exp 0",
               rec.out_len);
    end
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy got %b exp 0", busy);
    end
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL rst_done got %b exp 0", done);
    end
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL rst_ovf got %b exp 0", overflow);
    end
    if (num_ops !== '0) begin
      errs++;
      $display("FAIL rst_nops got %0d exp 0", num_ops);
    end
  endtask

  task automatic test_basic();
    rec.out_ready = 1'b1;
    dq = '{3, 3, 3, 1, 2, 2};
    play(0, 1'b0);
    wait_done("basic");
    vec += 4;
    if (got.size() != eq.size()) begin
      errs++;
      $display("FAIL basic nrec got %0d exp %0d",
               got.size(), eq.size());
    end else foreach (eq[i]) begin
      vec++;
      if (got[i] !== eq[i]) begin
        errs++;
        $display("FAIL basic rec%0d got %h exp %h",
                 i, got[i], eq[i]);
      end
    end
    if (num_ops !== OW'(eq.size())) begin
      errs++;
      $display("FAIL basic nops got %0d exp %0d",
               num_ops, eq.size());
    end
    if (done_cnt != 1 || got_at_done != eq.size()) begin
      errs++;
      $display("FAIL basic done got %0d@%0d exp 1@%0d",
               done_cnt, got_at_done, eq.size());
    end
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic ovf/busy got %b%b exp 00",
               overflow, busy);
    end
  endtask

  task automatic test_saturation();
    rec.out_ready = 1'b1;
    dq.delete();
    repeat (17) dq.push_back(3);
    play(1, 1'b0);
    wait_done("sat");
    vec += 2;
    if (got.size() != eq.size()) begin
      errs++;
      $display("FAIL sat nrec got %0d exp %0d",
               got.size(), eq.size());
    end else foreach (eq[i]) begin
      vec++;
      if (got[i] !== eq[i]) begin
        errs++;
        $display("FAIL sat rec%0d got %h exp %h",
                 i, got[i], eq[i]);
      end
    end
    if (num_ops !== OW'(eq.size())) begin
      errs++;
      $display("FAIL sat nops got %0d exp %0d",
               num_ops, eq.size());
    end
  endtask

  task automatic test_empty();
    rec.out_ready = 1'b1;
    dq.delete();
    play(0, 1'b0);
    wait_done("empty");
    vec += 3;
    if (got.size() != 1) begin
      errs++;
      $display("FAIL empty nrec got %0d exp 1",
               got.size());
    end else if (got[0] !== eq[0]) begin
      errs++;
      $display("FAIL empty rec got %h exp %h",
               got[0], eq[0]);
    end
    if (done_cnt != 1 || got_at_done != 1) begin
      errs++;
      $display("FAIL empty done got %0d@%0d exp 1@1",
               done_cnt, got_at_done);
    end
    if (num_ops !== OW'(1)) begin
      errs++;
      $display("FAIL empty nops got %0d exp 1",
               num_ops);
    end
  endtask

  task automatic test_simultaneous();
    rec.out_ready = 1'b1;
    dq = '{1, 2, 2, 2};
    play(2, 1'b1);
    wait_done("simul");
    vec++;
    if (got.size() != eq.size()) begin
      errs++;
      $display("FAIL simul nrec got %0d exp %0d",
               got.size(), eq.size());
    end else foreach (eq[i]) begin
      vec++;
      if (got[i] !== eq[i]) begin
        errs++;
        $display("FAIL simul rec%0d got %h exp %h",
                 i, got[i], eq[i]);
      end
    end
  endtask

  task automatic test_overflow();
    rec.out_ready = 1'b0;
    dq = '{3, 1, 3, 1, 3, 1};
    play(0, 1'b0);
    repeat (5) tick();
    vec += 4;
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf flag got %b exp 1", overflow);
    end
    if (num_ops !== OW'(4)) begin
      errs++;
      $display("FAIL ovf nops got %0d exp 4", num_ops);
    end
    if (busy !== 1'b1 || done_cnt != 0) begin
      errs++;
      $display("FAIL ovf stall got %b/%0d exp 1/0",
               busy, done_cnt);
    end
    if (rec.out_valid !== 1'b1 ||
        rec.out_op !== 2'd3) begin
      errs++;
      $display("FAIL ovf head got %b/%0d exp 1/3",
               rec.out_valid, rec.out_op);
    end
    eq.delete(4);
    rec.out_ready = 1'b1;
    wait_done("ovf");
    vec += 2;
    if (got.size() != eq.size()) begin
      errs++;
      $display("FAIL ovf nrec got %0d exp %0d",
               got.size(), eq.size());
    end else foreach (eq[i]) begin
      vec++;
      if (got[i] !== eq[i]) begin
        errs++;
        $display("FAIL ovf rec%0d got %h exp %h",
                 i, got[i], eq[i]);
      end
    end
    if (num_ops !== OW'(5)) begin
      errs++;
      $display("FAIL ovf nops2 got %0d exp 5", num_ops);
    end
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf sticky got %b exp 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    rec.out_ready = 1'b0;
    dq = '{3, 1, 2, 3};
    play(0, 1'b0);
    vec++;
    if (num_ops !== OW'(3)) begin
      errs++;
      $display("FAIL rmid pre got %0d exp 3", num_ops);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec += 3;
    if (rec.out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rmid vb got %b%b exp 00",
               rec.out_valid, busy);
    end
    if (num_ops !== '0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL rmid no got %0d/%b exp 0/0",
               num_ops, overflow);
    end
    rec.out_ready = 1'b1;
    repeat (10) tick();
    if (done_cnt != 0 || got.size() != 0) begin
      errs++;
      $display("FAIL rmid idle got %0d/%0d exp 0/0",
               done_cnt, got.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      dq.delete();
      if (it % 2 == 0) begin
        int n = $urandom_range(0, 40);
        int p = 0;
        rnd_rdy = 1'b0;
        rec.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
          int d = ($urandom_range(0, 2) != 0 && i > 0)
                  ? p : $urandom_range(0, 3);
          dq.push_back(d);
          p = d;
        end
      end else begin
        int k = $urandom_range(1, 5);
        int p = 0;
        rnd_rdy = 1'b1;
        for (int j = 0; j < k; j++) begin
          int op;
          int l = $urandom_range(1, MAXL);
          do op = $urandom_range(1, 3);
          while (op == p);
          for (int i = 0; i < l; i++) begin
            dq.push_back(op);
            if ($urandom_range(0, 4) == 0)
              dq.push_back(0);
          end
          p = op;
        end
      end
      play($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      wait_done("rand");
      rnd_rdy = 1'b0;
      rec.out_ready = 1'b1;
      vec += 4;
      if (got.size() != eq.size()) begin
        errs++;
        $display("FAIL rand%0d nrec got %0d exp %0d",
                 it, got.size(), eq.size());
      end else foreach (eq[i]) begin
        vec++;
        if (got[i] !== eq[i]) begin
          errs++;
          $display("FAIL rand%0d rec%0d got %h exp %h",
                   it, i, got[i], eq[i]);
        end
      end
      if (num_ops !== OW'(eq.size())) begin
        errs++;
        $display("FAIL rand%0d nops got %0d exp %0d",
                 it, num_ops, eq.size());
      end
      if (overflow !== 1'b0) begin
        errs++;
        $display("FAIL rand%0d ovf got %b exp 0",
                 it, overflow);
      end
      if (done_cnt != 1 || got_at_done != eq.size()) begin
        errs++;
        $display("FAIL rand%0d done got %0d@%0d exp 1@%0d",
                 it, done_cnt, got_at_done, eq.size());
      end
    end
  endtask

  initial begin
    rec.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_empty();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_basic();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
